// File: rtl/comb_test_driver.sv
// Stimulus/response driver for the combinational priority-assignment block:
// LFSR vectors out on src1..src3, responses on out1..out5 checked one cycle later.
module comb_test_driver #(
    parameter int          size        = 1,
    parameter int          NUM_VECTORS = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [size-1:0] src1,
    output logic [size-1:0] src2,
    output logic [size-1:0] src3,
    input  logic [size-1:0] out1,
    input  logic [size-1:0] out2,
    input  logic [size-1:0] out3,
    input  logic [size-1:0] out4,
    input  logic [size-1:0] out5,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [7:0]      first_fail,
    output logic [4:0]      fail_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_adv;
    logic [7:0]      index;
    logic            last_vector;
    logic            start_run;
    logic [size-1:0] e1, e2, e3, e4, e5;
    logic [4:0]      mismatch;
    logic [size-1:0] load1, load2, load3;

    assign lfsr_adv    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign last_vector = (index == 8'(NUM_VECTORS - 1));
    assign start_run   = start && (state == IDLE || state == DONE);

    // A new run loads the seed itself; later vectors come from the advanced LFSR
    assign load1 = (state == SAMPLE) ? lfsr_adv[size-1:0] : SEED[size-1:0];
    assign load2 = (state == SAMPLE) ? lfsr_adv[8+size-1:8] : SEED[8+size-1:8];
    assign load3 = (state == SAMPLE) ? (lfsr_adv[size-1:0] ^ lfsr_adv[8+size-1:8])
                                     : (SEED[size-1:0] ^ SEED[8+size-1:8]);

    // Reference behaviour: the unconditional write to out3 overrides its earlier
    // conditional write, and out5 takes the first true branch of an if/else chain
    assign e1 = src2[0] ? src2 : src1;
    assign e2 = src2;
    assign e3 = src1;
    assign e4 = src2[0] ? src2 : src1;
    assign e5 = src2[0] ? src2 : (src3[0] ? src3 : src1);

    // Case inequality so X/Z on a response is caught as a failure
    assign mismatch = {out5 !== e5, out4 !== e4, out3 !== e3, out2 !== e2, out1 !== e1};

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_count == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRIVE;
            DRIVE:   next_state = SAMPLE;
            SAMPLE:  next_state = last_vector ? DONE : DRIVE;
            DONE:    if (start) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Run bookkeeping: results are only updated on SAMPLE edges and held in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= SEED;
            index      <= 8'd0;
            src1       <= '0;
            src2       <= '0;
            src3       <= '0;
            err_count  <= 8'd0;
            first_fail <= 8'hFF;
            fail_mask  <= 5'd0;
        end else if (start_run) begin
            lfsr       <= SEED;
            index      <= 8'd0;
            src1       <= load1;
            src2       <= load2;
            src3       <= load3;
            err_count  <= 8'd0;
            first_fail <= 8'hFF;
            fail_mask  <= 5'd0;
        end else if (state == SAMPLE) begin
            if (|mismatch) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (first_fail == 8'hFF) first_fail <= index;
                fail_mask <= fail_mask | mismatch;
            end
            if (!last_vector) begin
                index <= index + 8'd1;
                lfsr  <= lfsr_adv;
                src1  <= load1;
                src2  <= load2;
                src3  <= load3;
            end
        end
    end

endmodule

// File: tb/tb_comb_test_driver.sv
// Bench for comb_test_driver: a behavioural responder (optionally faulty) answers the
// driver, and a scoreboard of predicted vectors and run results is checked against it.
module tb_comb_test_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   fault = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   phase = 1'b0;

    logic [23:0] sb[$];
    logic [7:0]  exp_err;
    logic [7:0]  exp_first;
    logic [4:0]  exp_mask;

    always #5 clk = ~clk;

    // Instance A: size 4, 16 vectors
    logic [3:0] a_s1, a_s2, a_s3, a_o1, a_o2, a_o3, a_o4, a_o5;
    logic a_busy, a_done, a_pass, a_start;
    logic [7:0] a_err, a_first;
    logic [4:0] a_mask;
    logic [39:0] a_r;
    // Instance B: size 8, 16 vectors
    logic [7:0] b_s1, b_s2, b_s3, b_o1, b_o2, b_o3, b_o4, b_o5;
    logic b_busy, b_done, b_pass, b_start;
    logic [7:0] b_err, b_first;
    logic [4:0] b_mask;
    logic [39:0] b_r;
    // Instance C: size 4, 255 vectors
    logic [3:0] c_s1, c_s2, c_s3, c_o1, c_o2, c_o3, c_o4, c_o5;
    logic c_busy, c_done, c_pass, c_start;
    logic [7:0] c_err, c_first;
    logic [4:0] c_mask;
    logic [39:0] c_r;
    // Instance D: size 4, single vector
    logic [3:0] d_s1, d_s2, d_s3, d_o1, d_o2, d_o3, d_o4, d_o5;
    logic d_busy, d_done, d_pass, d_start;
    logic [7:0] d_err, d_first;
    logic [4:0] d_mask;
    logic [39:0] d_r;

    logic [7:0] obs_s1, obs_s2, obs_s3, obs_err, obs_first;
    logic [4:0] obs_mask;
    logic       obs_busy, obs_done, obs_pass;

    // Block under test as the driver should see it; fault selects a planted bug
    function automatic logic [39:0] resp(input logic [7:0] s1, input logic [7:0] s2,
                                         input logic [7:0] s3, input int w, input int f);
        logic [7:0] m, o1, o2, o3, o4, o5;
        m  = 8'hFF >> (8 - w);
        o1 = s2[0] ? s2 : s1;
        o2 = s2;
        o3 = s1;
        o4 = s2[0] ? s2 : s1;
        o5 = s2[0] ? s2 : (s3[0] ? s3 : s1);
        if (f == 1) o3 = 8'h00;
        if (f == 2) o5 = s2[0] ? s2 : s1;
        if (f == 3) begin
            o1 = ~o1 & m; o2 = ~o2 & m; o3 = ~o3 & m; o4 = ~o4 & m; o5 = ~o5 & m;
        end
        return {o5, o4, o3, o2, o1};
    endfunction

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign c_start = start && (sel == 2);
    assign d_start = start && (sel == 3);

    assign a_r = resp({4'h0, a_s1}, {4'h0, a_s2}, {4'h0, a_s3}, 4, fault);
    assign b_r = resp(b_s1, b_s2, b_s3, 8, fault);
    assign c_r = resp({4'h0, c_s1}, {4'h0, c_s2}, {4'h0, c_s3}, 4, fault);
    assign d_r = resp({4'h0, d_s1}, {4'h0, d_s2}, {4'h0, d_s3}, 4, fault);
    assign {a_o5, a_o4, a_o3, a_o2, a_o1} = {a_r[35:32], a_r[27:24], a_r[19:16], a_r[11:8], a_r[3:0]};
    assign {b_o5, b_o4, b_o3, b_o2, b_o1} = b_r;
    assign {c_o5, c_o4, c_o3, c_o2, c_o1} = {c_r[35:32], c_r[27:24], c_r[19:16], c_r[11:8], c_r[3:0]};
    assign {d_o5, d_o4, d_o3, d_o2, d_o1} = {d_r[35:32], d_r[27:24], d_r[19:16], d_r[11:8], d_r[3:0]};

    comb_test_driver #(.size(4), .NUM_VECTORS(16), .SEED(16'hACE1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .src1(a_s1), .src2(a_s2), .src3(a_s3),
        .out1(a_o1), .out2(a_o2), .out3(a_o3), .out4(a_o4), .out5(a_o5),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_fail(a_first), .fail_mask(a_mask));

    comb_test_driver #(.size(8), .NUM_VECTORS(16), .SEED(16'hACE1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .src1(b_s1), .src2(b_s2), .src3(b_s3),
        .out1(b_o1), .out2(b_o2), .out3(b_o3), .out4(b_o4), .out5(b_o5),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_fail(b_first), .fail_mask(b_mask));

    comb_test_driver #(.size(4), .NUM_VECTORS(255), .SEED(16'hACE1)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .src1(c_s1), .src2(c_s2), .src3(c_s3),
        .out1(c_o1), .out2(c_o2), .out3(c_o3), .out4(c_o4), .out5(c_o5),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .first_fail(c_first), .fail_mask(c_mask));

    comb_test_driver #(.size(4), .NUM_VECTORS(1), .SEED(16'hACE1)) dut_d (
        .clk(clk), .reset(reset), .start(d_start), .src1(d_s1), .src2(d_s2), .src3(d_s3),
        .out1(d_o1), .out2(d_o2), .out3(d_o3), .out4(d_o4), .out5(d_o5),
        .busy(d_busy), .done(d_done), .pass(d_pass), .err_count(d_err),
        .first_fail(d_first), .fail_mask(d_mask));

    always_comb begin
        obs_s1 = {4'h0, a_s1}; obs_s2 = {4'h0, a_s2}; obs_s3 = {4'h0, a_s3};
        obs_busy = a_busy; obs_done = a_done; obs_pass = a_pass;
        obs_err = a_err; obs_first = a_first; obs_mask = a_mask;
        case (sel)
            1: begin
                obs_s1 = b_s1; obs_s2 = b_s2; obs_s3 = b_s3;
                obs_busy = b_busy; obs_done = b_done; obs_pass = b_pass;
                obs_err = b_err; obs_first = b_first; obs_mask = b_mask;
            end
            2: begin
                obs_s1 = {4'h0, c_s1}; obs_s2 = {4'h0, c_s2}; obs_s3 = {4'h0, c_s3};
                obs_busy = c_busy; obs_done = c_done; obs_pass = c_pass;
                obs_err = c_err; obs_first = c_first; obs_mask = c_mask;
            end
            3: begin
                obs_s1 = {4'h0, d_s1}; obs_s2 = {4'h0, d_s2}; obs_s3 = {4'h0, d_s3};
                obs_busy = d_busy; obs_done = d_done; obs_pass = d_pass;
                obs_err = d_err; obs_first = d_first; obs_mask = d_mask;
            end
            default: ;
        endcase
    end

    // Predict every vector of a run plus the final result registers
    task automatic build_queue(input int nvec, input int w, input int f);
        logic [15:0] l;
        logic [7:0]  m, s1, s2, s3;
        logic [39:0] good, got;
        logic [4:0]  mm;
        sb.delete();
        l = 16'hACE1;
        m = 8'hFF >> (8 - w);
        exp_err = 8'd0; exp_first = 8'hFF; exp_mask = 5'd0;
        for (int k = 0; k < nvec; k++) begin
            s1 = l[7:0] & m;
            s2 = l[15:8] & m;
            s3 = (l[7:0] ^ l[15:8]) & m;
            sb.push_back({s1, s2, s3});
            good = resp(s1, s2, s3, w, 0);
            got  = resp(s1, s2, s3, w, f);
            for (int i = 0; i < 5; i++) mm[i] = (good[i*8 +: 8] != got[i*8 +: 8]);
            if (mm != 5'd0) begin
                if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                if (exp_first == 8'hFF) exp_first = 8'(k);
                exp_mask = exp_mask | mm;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    // Each new vector appears on the first busy cycle (DRIVE) of its pair
    always @(negedge clk) begin
        if (reset || !obs_busy) begin
            phase = 1'b0;
        end else begin
            if (!phase) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL vector_unexpected: got %h_%h_%h with no vector pending",
                             obs_s1, obs_s2, obs_s3);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    if ({obs_s1, obs_s2, obs_s3} !== e) begin
                        mismatched++;
                        $display("[TB] FAIL vector_src: got %h_%h_%h want %h_%h_%h",
                                 obs_s1, obs_s2, obs_s3, e[23:16], e[15:8], e[7:0]);
                    end
                end
            end
            phase = ~phase;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (!obs_done && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        compared++;
        if ({obs_busy, obs_done, obs_pass} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b want 000", {obs_busy, obs_done, obs_pass});
        end
        compared++;
        if ({obs_err, obs_first, obs_mask} !== {8'd0, 8'hFF, 5'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_results: got %h %h %b want 00 ff 00000", obs_err, obs_first, obs_mask);
        end
        compared++;
        if ({obs_s1, obs_s2, obs_s3} !== 24'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_src: got %h_%h_%h want 0", obs_s1, obs_s2, obs_s3);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({obs_busy, obs_done} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL idle_hold: got busy/done %b want 00", {obs_busy, obs_done});
        end
    endtask

    task automatic test_correct();
        int cycles;
        sel = 0; fault = 0;
        build_queue(16, 4, 0);
        pulse_start();
        compared++;
        if ({obs_s1, obs_s2, obs_s3} !== 24'h010C0D) begin
            mismatched++;
            $display("[TB] FAIL correct_vector0: got %h_%h_%h want 01_0c_0d", obs_s1, obs_s2, obs_s3);
        end
        compared++;
        if ({obs_busy, obs_done} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL correct_busy: got busy/done %b want 10", {obs_busy, obs_done});
        end
        wait_done(60, cycles);
        compared++;
        if (cycles != 32) begin
            mismatched++;
            $display("[TB] FAIL correct_done_time: got %0d edges want 32", cycles);
        end
        compared++;
        if ({obs_pass, obs_err, obs_first, obs_mask} !== {1'b1, 8'd0, 8'hFF, 5'd0}) begin
            mismatched++;
            $display("[TB] FAIL correct_result: got pass %b err %h first %h mask %b want 1 00 ff 00000",
                     obs_pass, obs_err, obs_first, obs_mask);
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL correct_vectors_left: got %0d want 0", sb.size());
        end
    endtask

    task automatic test_stuck_out3();
        int cycles;
        sel = 0; fault = 1;
        build_queue(16, 4, 1);
        pulse_start();
        wait_done(60, cycles);
        compared++;
        if (cycles != 32) begin
            mismatched++;
            $display("[TB] FAIL stuck_done_time: got %0d edges want 32", cycles);
        end
        compared++;
        if ({obs_pass, obs_first, obs_mask} !== {1'b0, 8'd0, 5'b00100}) begin
            mismatched++;
            $display("[TB] FAIL stuck_flags: got pass %b first %h mask %b want 0 00 00100",
                     obs_pass, obs_first, obs_mask);
        end
        compared++;
        if (obs_err !== exp_err) begin
            mismatched++;
            $display("[TB] FAIL stuck_err_count: got %0d want %0d", obs_err, exp_err);
        end
    endtask

    task automatic test_out5_branch();
        int cycles;
        sel = 1; fault = 2;
        build_queue(16, 8, 2);
        pulse_start();
        wait_done(60, cycles);
        compared++;
        if (cycles != 32) begin
            mismatched++;
            $display("[TB] FAIL out5_done_time: got %0d edges want 32", cycles);
        end
        compared++;
        if ({obs_pass, obs_mask} !== {1'b0, 5'b10000}) begin
            mismatched++;
            $display("[TB] FAIL out5_mask: got pass %b mask %b want 0 10000", obs_pass, obs_mask);
        end
        compared++;
        if ({obs_first, obs_err} !== {exp_first, exp_err}) begin
            mismatched++;
            $display("[TB] FAIL out5_first_err: got %h %0d want %h %0d", obs_first, obs_err, exp_first, exp_err);
        end
    endtask

    task automatic test_reset_midrun();
        sel = 0; fault = 1;
        build_queue(16, 4, 1);
        pulse_start();
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({obs_busy, obs_done, obs_err, obs_first} !== {2'b00, 8'd0, 8'hFF}) begin
            mismatched++;
            $display("[TB] FAIL midrun_abort: got busy %b done %b err %h first %h want 0 0 00 ff",
                     obs_busy, obs_done, obs_err, obs_first);
        end
        compared++;
        if ({obs_s1, obs_s2, obs_s3} !== 24'd0) begin
            mismatched++;
            $display("[TB] FAIL midrun_src: got %h_%h_%h want 0", obs_s1, obs_s2, obs_s3);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_correct();
    endtask

    task automatic test_start_ignored();
        int cycles;
        sel = 0; fault = 1;
        build_queue(16, 4, 1);
        pulse_start();
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            start = (c == 6) || (c == 32);
            if (c == 32) begin
                compared++;
                if ({obs_busy, obs_done} !== 2'b10) begin
                    mismatched++;
                    $display("[TB] FAIL ignore_last_sample: got busy/done %b want 10", {obs_busy, obs_done});
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        compared++;
        if ({obs_busy, obs_done} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL ignore_done_entry: got busy/done %b want 01", {obs_busy, obs_done});
        end
        @(negedge clk);
        compared++;
        if ({obs_done, obs_err} !== {1'b1, exp_err}) begin
            mismatched++;
            $display("[TB] FAIL ignore_done_hold: got done %b err %0d want 1 %0d", obs_done, obs_err, exp_err);
        end
        fault = 0;
        build_queue(16, 4, 0);
        pulse_start();
        compared++;
        if ({obs_busy, obs_err, obs_first, obs_mask} !== {1'b1, 8'd0, 8'hFF, 5'd0}) begin
            mismatched++;
            $display("[TB] FAIL restart_cleared: got busy %b err %h first %h mask %b want 1 00 ff 00000",
                     obs_busy, obs_err, obs_first, obs_mask);
        end
        wait_done(60, cycles);
        compared++;
        if ({obs_pass, 32'(cycles)} !== {1'b1, 32'd32}) begin
            mismatched++;
            $display("[TB] FAIL restart_result: got pass %b after %0d edges want 1 after 32", obs_pass, cycles);
        end
    endtask

    task automatic test_single_vector();
        int cycles;
        sel = 3; fault = 0;
        build_queue(1, 4, 0);
        pulse_start();
        wait_done(20, cycles);
        compared++;
        if (cycles != 2) begin
            mismatched++;
            $display("[TB] FAIL single_done_time: got %0d edges want 2", cycles);
        end
        compared++;
        if ({obs_pass, obs_err, obs_first} !== {1'b1, 8'd0, 8'hFF}) begin
            mismatched++;
            $display("[TB] FAIL single_result: got pass %b err %h first %h want 1 00 ff", obs_pass, obs_err, obs_first);
        end
    endtask

    task automatic test_saturate();
        int cycles;
        sel = 2; fault = 3;
        build_queue(255, 4, 3);
        pulse_start();
        wait_done(600, cycles);
        compared++;
        if (cycles != 510) begin
            mismatched++;
            $display("[TB] FAIL sat_done_time: got %0d edges want 510", cycles);
        end
        compared++;
        if ({obs_pass, obs_err, obs_first, obs_mask} !== {1'b0, 8'd255, 8'd0, 5'b11111}) begin
            mismatched++;
            $display("[TB] FAIL sat_result: got pass %b err %0d first %h mask %b want 0 255 00 11111",
                     obs_pass, obs_err, obs_first, obs_mask);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_out3();
        test_out5_branch();
        test_reset_midrun();
        test_start_ignored();
        test_single_vector();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/comb_test_driver.md
Name: comb_test_driver

Overview:
- Self-checking stimulus/response companion for the combinational priority-assignment test block (ports src1..src3 in, out1..out5 out).
- Drives src1..src3 from an LFSR and samples out1..out5 one cycle later.
- Compares each sample against an internal model of last-assignment-wins / if-else-priority semantics, and reports pass/fail, error count and first failing vector.
- Sits in the comb systest harness, one instance per width under test.

Parameters:
size, 1, width of every src/out vector; legal 1..8
NUM_VECTORS, 16, vectors per run; legal 1..255
SEED, 16'hACE1, LFSR load value; must be nonzero

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin run; honoured only in IDLE or DONE
src1  output  size  stimulus vector 1
src2  output  size  stimulus vector 2
src3  output  size  stimulus vector 3
out1  input  size  DUT response 1
out2  input  size  DUT response 2
out3  input  size  DUT response 3
out4  input  size  DUT response 4
out5  input  size  DUT response 5
busy  output  1  high in DRIVE/SAMPLE
done  output  1  high in DONE
pass  output  1  done and err_count==0
err_count  output  8  mismatching vectors, saturates at 255
first_fail  output  8  index of first mismatching vector; 8'hFF if none
fail_mask  output  5  sticky per-output mismatch flags, bit i-1 = out<i>

Behaviour:
Reset:
- Asynchronous: state=IDLE, lfsr=SEED, src1..src3=0, index=0, err_count=0, first_fail=8'hFF, fail_mask=0.
- busy=0, done=0, pass=0.
- Reset mid-run aborts immediately to these values.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11; shift left, new bit0 = l[15]^l[13]^l[12]^l[10].
- Advances only on SAMPLE edges.

Stimulus mapping (vector from current lfsr l):
- src1=l[size-1:0]
- src2=l[8+size-1:8]
- src3=(l[7:0]^l[15:8])[size-1:0]

Expected model, from the registered src values:
- e1 = src2[0] ? src2 : src1
- e2 = src2
- e3 = src1 (the prior conditional write is dead)
- e4 = src2[0] ? src2 : src1
- e5 = src2[0] ? src2 : (src3[0] ? src3 : src1)

FSM:
- IDLE: on start, load lfsr=SEED, index=0, clear err_count/first_fail/fail_mask, load src from SEED; go to DRIVE.
- DRIVE: one settle cycle, no updates; go to SAMPLE.
- SAMPLE: compare all five outputs (full size bits, 4-state X/Z counts as mismatch in simulation).
  - Any mismatch: err_count++ (saturating at 255); first_fail=index if still 8'hFF; OR mismatch bits into fail_mask.
  - If index==NUM_VECTORS-1: go to DONE.
  - Otherwise: index++, advance lfsr, load src from the advanced value, go to DRIVE.
- DONE: src held; results held; done=1. start restarts exactly as from IDLE.

Timing and boundaries:
- 2 cycles per vector.
- done rises 2*NUM_VECTORS edges after the start-accepting edge.
- start while busy is ignored.
- start and the final SAMPLE edge in the same cycle: start is ignored, DONE is entered.
- NUM_VECTORS=1: single compare, done after 2 edges.

Test Plan:
1. size=4, correct DUT, start pulse → vector0 src1=4'h1, src2=4'hC, src3=4'hD; DUT gives 1,C,1,1,D. done exactly 32 cycles after start; pass=1, err_count=0, first_fail=8'hFF, fail_mask=0.
2. size=4, DUT out3 stuck at 4'h0 → mismatch whenever src1≠0. Vector0 fails, so first_fail=0, fail_mask=5'b00100, err_count = number of vectors with src1≠0, pass=0.
3. size=8, DUT out5 wrongly ignores the src3 branch → fail_mask=5'b10000, first_fail = first index with src2[0]=0, src3[0]=1, src3≠src1.
4. reset asserted mid-run, 5 cycles after start → async clear within the same cycle: busy=0, src=0, err_count=0. A new start reproduces scenario 1 exactly.
5. start pulsed during DRIVE/SAMPLE and again in DONE → first ignored (timing unchanged); second restarts with counters cleared and vector0 = SEED values.
6. NUM_VECTORS=255, DUT forced all-wrong (outputs inverted) → err_count=255 (saturates, no wrap), first_fail=0, fail_mask=5'b11111.
